// File: rtl/spi_burst_ram.sv
// rtl/spi_burst_ram.sv - SPI slave with burst read/write access to an internal RAM
module spi_burst_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic ss_n,
    input  logic MOSI,
    output logic MISO,
    output logic MISO_oe,
    output logic busy,
    output logic frame_err
);

    localparam int CNT_W = $clog2(DATA_WIDTH + ADDR_WIDTH + 1);
    localparam logic [CNT_W-1:0]      ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0]      DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] MEM_LAST  = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WRITE,
        S_READ_TA,
        S_READ,
        S_IGNORE
    } state_t;

    state_t                  state_q, state_d;
    logic                    armed_q, armed_d;
    logic                    cmd1_q, cmd1_d;
    logic                    is_read_q, is_read_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   wr_q, wr_d;
    logic [DATA_WIDTH-1:0]   tx_q, tx_d;
    logic                    miso_q, miso_d;
    logic                    oe_q, oe_d;
    logic                    err_q, err_d;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]   mem_rd;
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [ADDR_WIDTH-1:0]   addr_full;
    logic [DATA_WIDTH-1:0]   wr_full;

    // Burst address advance wraps at the last implemented word, not at 2**ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] addr_next(input logic [ADDR_WIDTH-1:0] a);
        return (a == MEM_LAST) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    assign mem_rd    = mem[addr_q];
    assign addr_full = {addr_q[ADDR_WIDTH-2:0], MOSI};
    assign wr_full   = {wr_q[DATA_WIDTH-2:0], MOSI};

    // Frame sequencing: one SPI bit per clk edge while ss_n is low.
    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        cmd1_d    = cmd1_q;
        is_read_d = is_read_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        tx_d      = tx_q;
        miso_d    = 1'b0;
        oe_d      = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = wr_full;

        if (ss_n) begin
            // Deselect ends any frame; a partially shifted write word is an error.
            state_d = S_IDLE;
            armed_d = 1'b1;
            if (state_q == S_WRITE && cnt_q != '0) begin
                err_d = 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Only a fresh select (seen high since reset) may start a frame.
                    if (armed_q) begin
                        state_d = S_CMD;
                        cmd1_d  = MOSI;
                        armed_d = 1'b0;
                    end
                end
                S_CMD: begin
                    if (cmd1_q) begin
                        state_d = S_IGNORE;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = S_ADDR;
                        is_read_d = MOSI;
                        cnt_d     = '0;
                    end
                end
                S_ADDR: begin
                    addr_d = addr_full;
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d = '0;
                        if ({1'b0, addr_full} >= DEPTH_EXT) begin
                            state_d = S_IGNORE;
                            err_d   = 1'b1;
                        end else begin
                            state_d = is_read_q ? S_READ_TA : S_WRITE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_WRITE: begin
                    wr_d = wr_full;
                    if (cnt_q == DATA_LAST) begin
                        mem_we = 1'b1;
                        addr_d = addr_next(addr_q);
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_READ_TA: begin
                    // Turnaround edge: fetch the first word so its MSB appears next cycle.
                    tx_d    = mem_rd;
                    addr_d  = addr_next(addr_q);
                    cnt_d   = '0;
                    miso_d  = mem_rd[DATA_WIDTH-1];
                    oe_d    = 1'b1;
                    state_d = S_READ;
                end
                S_READ: begin
                    if (cnt_q == DATA_LAST) begin
                        tx_d   = mem_rd;
                        addr_d = addr_next(addr_q);
                        cnt_d  = '0;
                    end else begin
                        tx_d  = {tx_q[DATA_WIDTH-2:0], 1'b0};
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    miso_d = tx_d[DATA_WIDTH-1];
                    oe_d   = 1'b1;
                end
                default: begin
                    state_d = S_IGNORE;
                end
            endcase
        end
    end

    // State and registered outputs; memory contents survive reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            armed_q   <= 1'b0;
            cmd1_q    <= 1'b0;
            is_read_q <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            wr_q      <= '0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            cmd1_q    <= cmd1_d;
            is_read_q <= is_read_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            err_q     <= err_d;
        end
    end

    // RAM write port, written on the edge that samples a word's LSB.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[addr_q] <= mem_wdata;
        end
    end

    assign MISO      = miso_q;
    assign MISO_oe   = oe_q;
    assign busy      = (state_q != S_IDLE);
    assign frame_err = err_q;

endmodule

// File: tb/tb_spi_burst_ram.sv
// tb/tb_spi_burst_ram.sv - scoreboard bench for spi_burst_ram with a word-level memory model
module tb_spi_burst_ram;

    localparam int H = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic ss0_n = 1'b1, mosi0 = 1'b0, ss1_n = 1'b1, mosi1 = 1'b0;
    logic miso0, oe0, busy0, err0, miso1, oe1, busy1, err1;

    spi_burst_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(256)) u_dut (
        .clk(clk), .rst(rst), .ss_n(ss0_n), .MOSI(mosi0),
        .MISO(miso0), .MISO_oe(oe0), .busy(busy0), .frame_err(err0)
    );

    spi_burst_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(200)) u_dut200 (
        .clk(clk), .rst(rst), .ss_n(ss1_n), .MOSI(mosi1),
        .MISO(miso1), .MISO_oe(oe1), .busy(busy1), .frame_err(err1)
    );

    typedef enum int {R_RESET, R_MARK, R_BUSYCNT, R_QUIET} req_kind_t;
    typedef struct { int cyc; req_kind_t kind; int expv; } req_t;
    typedef struct { int cyc; logic b; } bit_t;

    req_t      req_q[$];
    bit_t      exp_q[$];
    int        err_q[$];
    logic [7:0] wdata_q[$];
    logic [7:0] model [2][256];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int sel = 0;
    bit started = 1'b0;
    bit done = 1'b0;
    int checks = 0;
    int failures = 0;
    int busy_total = 0;
    int busy_mark = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endfunction

    // Monitor: compares the selected DUT's outputs against queued expectations.
    logic m_miso, m_oe, m_busy, m_err;
    int   exp_err, exp_oe;
    always @(negedge clk) begin
        if (started) begin
            m_miso = (sel != 0) ? miso1 : miso0;
            m_oe   = (sel != 0) ? oe1 : oe0;
            m_busy = (sel != 0) ? busy1 : busy0;
            m_err  = (sel != 0) ? err1 : err0;
            busy_total = busy_total + int'(m_busy);

            exp_oe = (exp_q.size() > 0 && exp_q[0].cyc == cyc) ? 1 : 0;
            chk("miso_oe", int'(m_oe), exp_oe);
            if (exp_oe != 0) begin
                chk("miso_bit", int'(m_miso), int'(exp_q[0].b));
                void'(exp_q.pop_front());
            end else begin
                chk("miso_idle_zero", int'(m_miso), 0);
            end

            exp_err = (err_q.size() > 0 && err_q[0] == cyc) ? 1 : 0;
            chk("frame_err", int'(m_err), exp_err);
            if (exp_err != 0) void'(err_q.pop_front());

            while (req_q.size() > 0 && req_q[0].cyc == cyc) begin
                case (req_q[0].kind)
                    R_RESET: begin
                        chk("reset_miso", int'(m_miso), 0);
                        chk("reset_oe", int'(m_oe), 0);
                        chk("reset_busy", int'(m_busy), 0);
                        chk("reset_err", int'(m_err), 0);
                    end
                    R_QUIET: begin
                        chk("post_reset_busy", int'(m_busy), 0);
                        chk("post_reset_oe", int'(m_oe), 0);
                    end
                    R_MARK: busy_mark = busy_total;
                    R_BUSYCNT: chk("busy_cycles", busy_total - busy_mark, req_q[0].expv);
                    default: ;
                endcase
                void'(req_q.pop_front());
            end

            if (done || cyc > 90000) begin
                chk("timeout", int'(cyc > 90000), 0);
                chk("leftover_miso", exp_q.size(), 0);
                chk("leftover_err", err_q.size(), 0);
                chk("leftover_req", req_q.size(), 0);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    task automatic drive(input logic s, input logic b);
        @(negedge clk);
        if (sel == 0) begin
            ss0_n = s;
            mosi0 = b;
        end else begin
            ss1_n = s;
            mosi1 = b;
        end
    endtask

    task automatic push_req(input int c, input req_kind_t k, input int v);
        req_t r;
        r.cyc = c;
        r.kind = k;
        r.expv = v;
        req_q.push_back(r);
    endtask

    // One frame: header, then nbits body edges (negative nbits cuts the header short).
    task automatic do_frame(input int cmd, input int addr, input int nbits,
                            input int busy_exp, input int rst_at);
        int depth;
        int total;
        int nw;
        bit rsv, bad, wr, rd, aborted;
        logic [7:0] w[$];
        bit_t e;
        depth = (sel == 0) ? 256 : 200;
        total = H + nbits;
        rsv = (cmd >= 2);
        bad = !rsv && (addr >= depth);
        wr = (cmd == 0) && !bad;
        rd = (cmd == 1) && !bad;
        aborted = 1'b0;
        nw = (nbits > 0) ? (nbits + 7) / 8 : 0;
        for (int i = 0; i < nw; i++) begin
            if (wdata_q.size() > 0) w.push_back(wdata_q.pop_front());
            else w.push_back(8'($urandom));
        end
        drive(1'b1, 1'b0);
        if (busy_exp >= 0) push_req(cyc + 1, R_MARK, 0);
        drive(1'b1, 1'b0);
        for (int n = 0; n < total; n++) begin
            int k;
            logic b;
            k = n - H;
            if (n < 2) b = cmd[1-n];
            else if (n < H) b = addr[H-1-n];
            else b = w[k/8][7-(k%8)];
            if (n == rst_at) begin
                drive(1'b0, b);
                rst = 1'b1;
                push_req(cyc + 1, R_QUIET, 0);
                for (int j = 0; j < 5; j++) begin
                    drive(1'b0, 1'($urandom));
                    rst = 1'b0;
                    push_req(cyc + 1, R_QUIET, 0);
                end
                aborted = 1'b1;
                break;
            end
            drive(1'b0, b);
            if (rsv && n == 1) err_q.push_back(cyc + 1);
            if (bad && n == H - 1) err_q.push_back(cyc + 1);
            if (wr && k >= 0 && (k % 8) == 7) model[sel][(addr + k / 8) % depth] = w[k/8];
            if (rd && k >= 0) begin
                e.cyc = cyc + 1;
                e.b = model[sel][(addr + k / 8) % depth][7-(k%8)];
                exp_q.push_back(e);
            end
        end
        drive(1'b1, 1'b0);
        if (!aborted && wr && nbits > 0 && (nbits % 8) != 0) err_q.push_back(cyc + 1);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        if (busy_exp >= 0) push_req(cyc + 1, R_BUSYCNT, busy_exp);
    endtask

    // Stimulus: directed scenarios, then randomized frames on both instances.
    initial begin
        int r, cmd, addr, nbits;
        repeat (3) @(negedge clk);
        push_req(cyc + 1, R_RESET, 0);
        started = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        sel = 0; do_frame(0, 0, 256 * 8, -1, -1);
        sel = 1; do_frame(0, 0, 200 * 8, -1, -1);
        sel = 0;

        wdata_q = '{8'hA5, 8'h3C, 8'hFF};
        do_frame(0, 'h10, 24, 34, -1);
        do_frame(1, 'h10, 24, -1, -1);

        wdata_q = '{8'h11, 8'h22};
        do_frame(0, 'hFF, 16, -1, -1);
        do_frame(1, 'hFF, 16, -1, -1);

        do_frame(3, 'h10, 12, -1, -1);
        do_frame(2, 'h11, 20, -1, -1);
        do_frame(1, 'h10, 24, -1, -1);

        wdata_q = '{8'h81, 8'h0F};
        do_frame(0, 'h20, 12, -1, -1);
        do_frame(1, 'h20, 16, -1, -1);

        do_frame(1, 'h40, 24, -1, H + 10);
        do_frame(1, 'h10, 24, -1, -1);

        sel = 1;
        do_frame(0, 'hC7, 8, -1, -1);
        do_frame(0, 'hC8, 16, -1, -1);
        do_frame(0, 'hFF, 8, -1, -1);
        do_frame(1, 'hC7, 16, -1, -1);
        do_frame(1, 'hC8, 8, -1, -1);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            cmd = (r < 4) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
            addr = $urandom_range(0, 255);
            nbits = int'($urandom_range(0, 44)) - 4;
            do_frame(cmd, addr, nbits, -1, -1);
        end

        sel = 0;
        do_frame(1, 0, 64, -1, -1);
        drive(1'b1, 1'b0);
        done = 1'b1;
        repeat (4) @(negedge clk);
    end

endmodule
